// File: rtl/dma_arb_pkg.sv
// Shared constants and FSM state encoding for the DMA request encoder/arbiter.
// Contents: NUM_CH / CH_W channel constants and the state_t enum.
// Imported by dma_prio_enc4 and dma_req_encoder.
package dma_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OFFER = 2'b01,
    BUSY  = 2'b10
  } state_t;

endpackage

// File: rtl/dma_prio_enc4.sv
// Combinational 4-way wrapping priority encoder.
// Ports: vec_i (request vector), start_i (first index to search),
//        idx_o (first set bit at or after start_i, wrapping), hit_o (any bit set).
module dma_prio_enc4
  import dma_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] vec_i,
  input  logic [CH_W-1:0]   start_i,
  output logic [CH_W-1:0]   idx_o,
  output logic              hit_o
);

  logic [CH_W-1:0] pos;

  // Scan from the farthest offset back to start_i so the nearest set bit
  // (smallest offset from start_i) is the last one written and wins.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    pos   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      pos = start_i + CH_W'(i);
      if (vec_i[pos]) begin
        idx_o = pos;
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_req_encoder.sv
// 4-to-2 DMA request encoder/arbiter with valid/ready offer and grant hold.
// Ports: clk_i/rst_ni, en_i, req_i, mask_i in; ch_o/ch_vld_o offered to core,
//        ch_rdy_i accepts, done_i ends the transfer, busy_o flags transfer in flight.
module dma_req_encoder
  import dma_arb_pkg::*;
#(
  parameter bit RR_EN  = 1'b1,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] mask_i,
  output logic [CH_W-1:0]   ch_o,
  output logic              ch_vld_o,
  input  logic              ch_rdy_i,
  input  logic              done_i,
  output logic              busy_o
);

  if (NUM_CH != 4 || CH_W != 2) begin : g_bad_cfg
    $error("dma_req_encoder supports only NUM_CH = 4 and CH_W = 2");
  end

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic [CH_W-1:0]   last_q, last_d;

  logic [NUM_CH-1:0] eff;
  logic [CH_W-1:0]   start;
  logic [CH_W-1:0]   win;
  logic              hit;

  assign eff = req_i & ~mask_i;

  // Round-robin searches from the channel after the last accepted grant;
  // fixed priority always starts at channel 0. last_q keeps updating either way.
  assign start = RR_EN ? (last_q + CH_W'(1)) : '0;

  dma_prio_enc4 u_prio (
    .vec_i   (eff),
    .start_i (start),
    .idx_o   (win),
    .hit_o   (hit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= '1;   // channel 0 gets first round-robin priority
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  // ch_o is never cleared on return to IDLE; it simply holds the last grant.
  // done_i is only looked at in BUSY and ch_rdy_i only in OFFER.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (en_i && hit) begin
          ch_d    = win;
          vld_d   = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // The offer is latched: req/mask/en changes cannot withdraw it.
        if (ch_rdy_i) begin
          vld_d   = 1'b0;
          busy_d  = 1'b1;
          last_d  = ch_q;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ch_o     = ch_q;
  assign ch_vld_o = vld_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_dma_req_encoder.sv
// Self-checking bench for dma_req_encoder: round-robin and fixed-priority
// instances share all inputs (their FSMs move in lockstep, only ch_o differs).
// Expected outputs are pushed to a scoreboard queue per cycle and popped after the edge.
module tb_dma_req_encoder;
  import dma_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] mask;
  logic       rdy;
  logic       done;

  logic [1:0] ch_rr, ch_fx;
  logic       vld_rr, vld_fx, busy_rr, busy_fx;

  always #5 clk = ~clk;

  dma_req_encoder #(.RR_EN(1'b1), .NUM_CH(4), .CH_W(2)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req), .mask_i(mask),
    .ch_o(ch_rr), .ch_vld_o(vld_rr), .ch_rdy_i(rdy), .done_i(done), .busy_o(busy_rr)
  );

  dma_req_encoder #(.RR_EN(1'b0), .NUM_CH(4), .CH_W(2)) dut_fx (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req), .mask_i(mask),
    .ch_o(ch_fx), .ch_vld_o(vld_fx), .ch_rdy_i(rdy), .done_i(done), .busy_o(busy_fx)
  );

  typedef struct packed {
    logic [1:0] ch_rr;
    logic [1:0] ch_fx;
    logic       vld;
    logic       busy;
  } exp_t;

  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_st;      // 0 idle, 1 offer, 2 busy
  logic [1:0] m_ch_rr, m_ch_fx, m_last_rr, m_last_fx;
  logic       m_vld, m_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] win(input logic [3:0] v, input logic [1:0] s);
    logic [1:0] r;
    logic       f;
    int         c;
    r = 2'd0;
    f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c = (int'(s) + i) % 4;
      if (!f && v[c]) begin
        r = 2'(c);
        f = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ch_rr = 2'd0; m_ch_fx = 2'd0; m_vld = 1'b0; m_busy = 1'b0;
    m_last_rr = 2'd3; m_last_fx = 2'd3;
  endtask

  task automatic model_step();
    logic [3:0] eff;
    eff = req & ~mask;
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_st)
        0: if (en && eff != 4'd0) begin
             m_ch_rr = win(eff, m_last_rr + 2'd1);
             m_ch_fx = win(eff, 2'd0);
             m_vld   = 1'b1;
             m_st    = 1;
           end
        1: if (rdy) begin
             m_vld = 1'b0; m_busy = 1'b1;
             m_last_rr = m_ch_rr; m_last_fx = m_ch_fx;
             m_st = 2;
           end
        default: if (done) begin
             m_busy = 1'b0;
             m_st   = 0;
           end
      endcase
    end
  endtask

  // One clock: model predicts, expectation queued, DUT sampled 1ns after the edge.
  task automatic cycle();
    exp_t e;
    model_step();
    sbq.push_back('{ch_rr: m_ch_rr, ch_fx: m_ch_fx, vld: m_vld, busy: m_busy});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_ch_rr",   ch_rr,   e.ch_rr);
    chk("sb_ch_fx",   ch_fx,   e.ch_fx);
    chk("sb_vld_rr",  vld_rr,  e.vld);
    chk("sb_vld_fx",  vld_fx,  e.vld);
    chk("sb_busy_rr", busy_rr, e.busy);
    chk("sb_busy_fx", busy_fx, e.busy);
  endtask

  // Clock until the offer appears; returns cycles spent, expired budget is a failure.
  task automatic wait_vld(input int budget, output int spent);
    spent = 0;
    while (!vld_rr && spent < budget) begin
      cycle();
      spent++;
    end
    if (!vld_rr) chk("wait_vld_timeout", 32'(spent), 32'(budget + 1));
  endtask

  task automatic grant_and_finish();
    rdy = 1'b1; cycle(); rdy = 1'b0;
    done = 1'b1; cycle(); done = 1'b0;
  endtask

  int         spent;
  logic [1:0] grants[$];
  int         exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 4'hF; mask = 4'h0; rdy = 1'b0; done = 1'b0;
    model_reset();
    #2;
    // Reset state with all requests active
    chk("rst_vld",  vld_rr,  1'b0);
    chk("rst_busy", busy_rr, 1'b0);
    chk("rst_ch",   ch_rr,   2'd0);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    chk("rel_vld", vld_rr, 1'b1);
    chk("rel_ch",  ch_rr,  2'd0);
    grant_and_finish();
    req = 4'h0; cycle();

    // Handshake hold: offer stays put while ready is low, even when req drops
    req = 4'b0100; cycle();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) req = 4'h0;
      cycle();
      chk("hold_ch",  ch_rr,  2'd2);
      chk("hold_vld", vld_rr, 1'b1);
    end
    rdy = 1'b1; cycle(); rdy = 1'b0;
    chk("acc_vld",  vld_rr,  1'b0);
    chk("acc_busy", busy_rr, 1'b1);
    done = 1'b1; cycle(); done = 1'b0;

    // Round-robin from a fresh reset, all channels requesting
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_vld(6, spent);
      if (g > 0) chk("rr_gap", 32'(spent + 1), 32'd2);
      grants.push_back(ch_rr);
      chk("fx_ch_const", ch_fx, 2'd0);
      grant_and_finish();
    end
    for (int g = 0; g < 5; g++) chk("rr_seq", 32'(grants[g]), 32'(exp_seq[g]));

    // Fixed priority: lowest unmasked channel
    req = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      wait_vld(6, spent);
      chk("fx_ch_1", ch_fx, 2'd1);
      grant_and_finish();
    end
    mask = 4'b0010;
    wait_vld(6, spent);
    chk("fx_ch_mask", ch_fx, 2'd3);
    grant_and_finish();
    mask = 4'h0;

    // Enable and mask gating
    req = 4'hF; en = 1'b0;
    for (int i = 0; i < 10; i++) begin cycle(); chk("gate_en", vld_rr, 1'b0); end
    en = 1'b1; mask = 4'hF;
    for (int i = 0; i < 10; i++) begin cycle(); chk("gate_mask", vld_rr, 1'b0); end
    mask = 4'h0;
    cycle();
    rdy = 1'b1; cycle(); rdy = 1'b0;
    en = 1'b0; cycle();
    done = 1'b1; cycle(); done = 1'b0;
    chk("en_off_done_busy", busy_rr, 1'b0);
    cycle();
    chk("en_off_idle_vld", vld_rr, 1'b0);
    en = 1'b1;

    // Spurious done in IDLE and OFFER, ready ignored in BUSY
    req = 4'h0; done = 1'b1; cycle(); cycle();
    chk("sp_idle_vld", vld_rr, 1'b0);
    chk("sp_idle_busy", busy_rr, 1'b0);
    done = 1'b0; req = 4'b0010; cycle();
    done = 1'b1; cycle();
    chk("sp_offer_vld", vld_rr, 1'b1);
    chk("sp_offer_busy", busy_rr, 1'b0);
    rdy = 1'b1; cycle();
    chk("sp_rdy_done_busy", busy_rr, 1'b1);
    done = 1'b0; cycle(); rdy = 1'b0;
    chk("sp_busy_hold", busy_rr, 1'b1);

    // Asynchronous reset in BUSY: clears immediately, next grant restarts at 0
    req = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_rr, 1'b0);
    chk("arst_vld",  vld_rr,  1'b0);
    chk("arst_ch",   ch_rr,   2'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    chk("arst_next_ch",  ch_rr,  2'd0);
    chk("arst_next_vld", vld_rr, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
